instr_issuer: RTL and testbench

- Program sequencer that drives the 20-bit `instruction` input of `simple_cpu`.
- Holds each instruction stable for exactly the number of cycles the CU FSM needs to retire it, then advances.
- Contains a small program store, loaded through a write port while idle, and a start/busy/done handshake toward the testbench or host.

---
 rtl/instr_issuer.sv | 147 ++++++++++++++
 tb/tb_instr_issuer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// instr_issuer: program sequencer that feeds the instruction input of simple_cpu.
// Each word is held for as many cycles as the CU FSM needs to retire it:
// 3 cycles for std_op and 4 for loadR/storeR. The first word after start is
// held one extra cycle to cover the CU's RESET->DECODE step.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   prog_wen     program store write enable (ignored while busy)
//   prog_addr    program store write address
//   prog_data    program word to write
//   start        begin issuing from entry 0 (accepted in IDLE only)
//   prog_len     number of entries to issue, sampled on start
//   instruction  word presented to the CPU (0 when not issuing)
//   pc           index of the word currently on instruction
//   busy         high while issuing
//   done         one-cycle pulse when issuing ends
module instr_issuer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_wen,
  input  logic [PROG_ADDR_BITS-1:0] prog_addr,
  input  logic [INSTR_WIDTH-1:0]    prog_data,
  input  logic                      start,
  input  logic [PROG_ADDR_BITS:0]   prog_len,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int DEPTH = 2 ** PROG_ADDR_BITS;
  localparam logic [PROG_ADDR_BITS:0] MAX_LEN = (PROG_ADDR_BITS + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [PROG_ADDR_BITS:0]   len_q, len_d;

  logic [INSTR_WIDTH-1:0]    mem [DEPTH];

  logic [INSTR_WIDTH-1:0]    cur_word, nxt_word, first_word;
  logic [PROG_ADDR_BITS-1:0] nxt_pc;
  logic [PROG_ADDR_BITS:0]   len_capped;
  logic                      is_last;

  // Cycles the CU spends on a word of the given type; type 00 is the halt marker.
  function automatic logic [2:0] hold_of(input logic [1:0] typ);
    case (typ)
      2'b01:   hold_of = 3'd3;
      2'b10:   hold_of = 3'd4;
      2'b11:   hold_of = 3'd4;
      default: hold_of = 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] type_of(input logic [INSTR_WIDTH-1:0] w);
    type_of = w[INSTR_WIDTH-1 -: 2];
  endfunction

  // Program store: not reset, writable only while not issuing.
  always_ff @(posedge clk) begin
    if (prog_wen && (state_q != S_ISSUE))
      mem[prog_addr] <= prog_data;
  end

  assign cur_word   = mem[pc_q];
  assign nxt_pc     = pc_q + 1'b1;
  // nxt_word aliases entry 0 when pc is the top index; is_last masks that case.
  assign nxt_word   = mem[nxt_pc];
  assign first_word = mem[0];
  assign is_last    = (({1'b0, pc_q} + (PROG_ADDR_BITS + 1)'(1)) == len_q);
  assign len_capped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    instruction = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_capped;
          if ((len_capped == '0) || (type_of(first_word) == 2'b00)) begin
            state_d = S_FINISH;
          end else begin
            pc_d    = '0;
            cnt_d   = hold_of(type_of(first_word)) + 3'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        instruction = cur_word;
        busy        = 1'b1;
        cnt_d       = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          if (is_last || (type_of(nxt_word) == 2'b00)) begin
            state_d = S_FINISH;
          end else begin
            pc_d  = nxt_pc;
            cnt_d = hold_of(type_of(nxt_word));
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
        len_d   = '0;
      end
    endcase
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed testbench for instr_issuer: single word, mixed program, halt marker,
// ignored requests while busy, zero and over-long lengths, reset mid-program.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_wen;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic [5:0]  prog_len;
  logic [19:0] instruction;
  logic [4:0]  pc;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [19:0] q_instr [$];
  logic [4:0]  q_pc    [$];

  int          busy_n;
  int          done_cyc;
  logic [4:0]  done_pc;
  int          idle_busy;

  instr_issuer #(.INSTR_WIDTH(20), .PROG_ADDR_BITS(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_wen    (prog_wen),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .prog_len    (prog_len),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input logic [4:0] a, input logic [19:0] d);
    @(negedge clk);
    prog_wen  = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_wen  = 1'b0;
  endtask

  // Pulses start, then records instruction/pc each busy cycle until done.
  // Cycle 1 is the first cycle after the start edge.
  task automatic run_prog(input logic [5:0] len, input bit inject,
                          output int nb, output int dc, output logic [4:0] dp);
    q_instr.delete();
    q_pc.delete();
    nb = 0;
    dc = 0;
    dp = '0;
    @(negedge clk);
    prog_len = len;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (inject && c == 2) begin
        prog_wen  = 1'b1;
        prog_addr = 5'd1;
        prog_data = 20'h4FFFF;
        start     = 1'b1;
      end else begin
        prog_wen = 1'b0;
        start    = 1'b0;
      end
      if (busy) begin
        nb++;
        q_instr.push_back(instruction);
        q_pc.push_back(pc);
      end
      if (done) begin
        dc = c;
        dp = pc;
        break;
      end
      @(negedge clk);
    end
    prog_wen = 1'b0;
    start    = 1'b0;
    if (dc == 0) check("done_timeout", 0, 1);
  endtask

  function automatic int count_word(input logic [4:0] p, input logic [19:0] w);
    int n = 0;
    foreach (q_pc[i]) if (q_pc[i] == p && q_instr[i] == w) n++;
    return n;
  endfunction

  initial begin
    rst       = 1'b1;
    prog_wen  = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    prog_len  = '0;

    // Reset asserted between edges.
    #2 rst = 1'b0;
    #1;
    check("rst_instr", instruction, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_pc",    pc, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single std_op: lead-in 1 + 3 = 4 cycles.
    write_word(5'd0, 20'h52130);
    run_prog(6'd1, 1'b0, busy_n, done_cyc, done_pc);
    check("single_busy", busy_n, 4);
    check("single_done", done_cyc, 5);
    check("single_word", count_word(5'd0, 20'h52130), 4);
    @(negedge clk);
    check("single_done_pulse", done, 0);

    // Mixed std_op, storeR, loadR: 4, 4, 4.
    write_word(5'd1, 20'hC1230);
    write_word(5'd2, 20'h81450);
    run_prog(6'd3, 1'b0, busy_n, done_cyc, done_pc);
    check("mixed_busy", busy_n, 12);
    check("mixed_done", done_cyc, 13);
    check("mixed_pc_end", done_pc, 2);
    check("mixed_w0", count_word(5'd0, 20'h52130), 4);
    check("mixed_w1", count_word(5'd1, 20'hC1230), 4);
    check("mixed_w2", count_word(5'd2, 20'h81450), 4);
    check("mixed_first_pc", q_pc[0], 0);
    check("mixed_pc_step", q_pc[4], 1);

    // Halt marker at entry 1.
    write_word(5'd1, 20'h00000);
    run_prog(6'd5, 1'b0, busy_n, done_cyc, done_pc);
    check("halt_busy", busy_n, 4);
    check("halt_done", done_cyc, 5);
    check("halt_pc", done_pc, 0);

    // Write and start while busy must be ignored.
    write_word(5'd1, 20'hC1230);
    run_prog(6'd3, 1'b1, busy_n, done_cyc, done_pc);
    check("ign_busy", busy_n, 12);
    check("ign_done", done_cyc, 13);
    check("ign_w1", count_word(5'd1, 20'hC1230), 4);
    idle_busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy || done) idle_busy++;
    end
    check("ign_no_rerun", idle_busy, 0);
    run_prog(6'd2, 1'b0, busy_n, done_cyc, done_pc);
    check("ign_readback", count_word(5'd1, 20'hC1230), 4);
    check("ign_readback_busy", busy_n, 8);

    // Zero length: done next cycle, never busy.
    run_prog(6'd0, 1'b0, busy_n, done_cyc, done_pc);
    check("len0_busy", busy_n, 0);
    check("len0_done", done_cyc, 1);

    // Reset during word 2, then reissue.
    q_pc.delete();
    @(negedge clk);
    prog_len = 6'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (busy && pc == 5'd1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("rstmid_reach_w2", seen, 1);
    end
    #2 rst = 1'b0;
    #1;
    check("rstmid_instr", instruction, 0);
    check("rstmid_busy",  busy, 0);
    check("rstmid_pc",    pc, 0);
    check("rstmid_done",  done, 0);
    @(negedge clk);
    rst = 1'b1;
    run_prog(6'd3, 1'b0, busy_n, done_cyc, done_pc);
    check("rstmid_re_pc0", q_pc[0], 0);
    check("rstmid_re_w0", q_instr[0], 20'h52130);
    check("rstmid_re_busy", busy_n, 12);

    // Length above capacity is capped at 32 entries.
    for (int i = 0; i < 32; i++) write_word(5'(i), 20'h40000 | 20'(i));
    run_prog(6'd40, 1'b0, busy_n, done_cyc, done_pc);
    check("full_busy", busy_n, 97);
    check("full_done", done_cyc, 98);
    check("full_pc_end", done_pc, 31);
    check("full_w1", q_instr[4], 20'h40001);
    check("full_last_w", q_instr[96], 20'h4001F);
    check("full_last_pc", q_pc[96], 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
